// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode
// values and the select/operation codes driven onto the datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ITYPE = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_SW    = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// State-to-strobe decode for the multicycle controller. Purely combinational;
// a few strobes are qualified by mem_ready/zero within their state.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        rtype,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic        wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op
);

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    alu_src_a = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    alu_src_b = SRCB_REG;
    pc_src    = PC_ALU;
    alu_op    = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      // ALUOut captures the branch target while the opcode is examined.
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        illegal   = !op_is_legal(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req   = 1'b1;
        mdr_write = mem_ready;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = rtype;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic        wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        rtype_q, rtype_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
      rtype_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      rtype_q   <= rtype_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rtype_d = rtype_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      // rtype remembers R vs I so WB_ALU can pick the destination field.
      S_DECODE: begin
        rtype_d = (opcode == OP_RTYPE);
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ITYPE:      state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires whenever control returns to FETCH, except the
  // very first fetch after reset and cycles spent waiting inside FETCH.
  always_comb begin
    retired_d = retired_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE))
      retired_d = retired_q + 32'd1;
  end

  assign retired = retired_q;

  ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .rtype     (rtype_q),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mdr_write (mdr_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .alu_src_a (alu_src_a),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .halted    (halted),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .alu_op    (alu_op)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle
// strobe vector and retired count; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, pc_write, ir_write, mdr_write, reg_write;
  logic        reg_dst, alu_src_a, wb_sel, illegal, halted;
  logic [1:0]  alu_src_b, pc_src, alu_op;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mdr_write (mdr_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .alu_src_a (alu_src_a),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .halted    (halted),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .alu_op    (alu_op),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: mem_req mem_we pc_write ir_write mdr_write reg_write
  // reg_dst alu_src_a wb_sel illegal halted | alu_src_b | pc_src | alu_op
  logic [16:0] obs_vec;
  assign obs_vec = {mem_req, mem_we, pc_write, ir_write, mdr_write, reg_write,
                    reg_dst, alu_src_a, wb_sel, illegal, halted,
                    alu_src_b, pc_src, alu_op};

  localparam logic [16:0] V_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_FWAIT   = 17'b1_0_0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_FGO     = 17'b1_0_1_1_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] V_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_1_0_11_00_00;
  localparam logic [16:0] V_EXR     = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_10;
  localparam logic [16:0] V_EXI     = 17'b0_0_0_0_0_0_0_1_0_0_0_10_00_00;
  localparam logic [16:0] V_ADDR    = 17'b0_0_0_0_0_0_0_1_0_0_0_10_00_00;
  localparam logic [16:0] V_MRW     = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MRG     = 17'b1_0_0_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MW      = 17'b1_1_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_WBR     = 17'b0_0_0_0_0_1_1_0_0_0_0_00_00_00;
  localparam logic [16:0] V_WBI     = 17'b0_0_0_0_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_WBM     = 17'b0_0_0_0_0_1_0_0_1_0_0_00_00_00;
  localparam logic [16:0] V_BRN     = 17'b0_0_0_0_0_0_0_1_0_0_0_00_01_01;
  localparam logic [16:0] V_BRZ     = 17'b0_0_1_0_0_0_0_1_0_0_0_00_01_01;
  localparam logic [16:0] V_JMP     = 17'b0_0_1_0_0_0_0_0_0_0_0_00_10_00;
  localparam logic [16:0] V_HLT     = 17'b0_0_0_0_0_0_0_0_0_0_1_00_00_00;

  typedef struct {
    logic [16:0] outv;
    logic [31:0] ret;
    int          step;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   step_no = 0;
  int   num_checks = 0;
  int   num_errors = 0;

  task automatic checkOutput(input string name, input int step,
                             input logic [16:0] got_v, input logic [16:0] exp_v,
                             input logic [31:0] got_r, input logic [31:0] exp_r);
    num_checks++;
    if (got_v !== exp_v) begin
      num_errors++;
      $display("[TB] FAIL %s step %0d strobes: got %b expected %b", name, step, got_v, exp_v);
    end
    num_checks++;
    if (got_r !== exp_r) begin
      num_errors++;
      $display("[TB] FAIL %s step %0d retired: got %0d expected %0d", name, step, got_r, exp_r);
    end
  endtask

  task automatic pushExp(input logic [16:0] ev, input logic [31:0] er);
    exp_t e;
    e.outv = ev;
    e.ret  = er;
    e.step = step_no;
    step_no++;
    sb_q.push_back(e);
  endtask

  // Drive this cycle's inputs just after the edge and record what the
  // controller should present for the rest of the cycle.
  task automatic applyStimulus(input logic [5:0] opc, input logic z, input logic rdy,
                               input logic [16:0] ev, input logic [31:0] er);
    @(posedge clk);
    #1;
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    pushExp(ev, er);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushExp(V_IDLE, 32'd0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checkOutput("cycle", mon_e.step, obs_vec, mon_e.outv, retired, mon_e.ret);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", -1, obs_vec, V_IDLE, retired, 32'd0);

    releaseReset();
    // R-type with memory always ready
    applyStimulus(6'h00, 1'b0, 1'b1, V_FGO, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_DEC, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_EXR, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_WBR, 32'd0);
    // I-type
    applyStimulus(6'h01, 1'b0, 1'b1, V_FGO, 32'd1);
    applyStimulus(6'h01, 1'b0, 1'b1, V_DEC, 32'd1);
    applyStimulus(6'h01, 1'b0, 1'b1, V_EXI, 32'd1);
    applyStimulus(6'h01, 1'b0, 1'b1, V_WBI, 32'd1);
    // LW with three wait cycles in MEM_RD
    applyStimulus(6'h02, 1'b0, 1'b1, V_FGO, 32'd2);
    applyStimulus(6'h02, 1'b0, 1'b1, V_DEC, 32'd2);
    applyStimulus(6'h02, 1'b0, 1'b1, V_ADDR, 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(6'h02, 1'b0, 1'b0, V_MRW, 32'd2);
    applyStimulus(6'h02, 1'b0, 1'b1, V_MRG, 32'd2);
    applyStimulus(6'h02, 1'b0, 1'b1, V_WBM, 32'd2);
    // BEQ not taken, with one fetch wait that must not retire anything
    applyStimulus(6'h04, 1'b0, 1'b0, V_FWAIT, 32'd3);
    applyStimulus(6'h04, 1'b0, 1'b1, V_FGO, 32'd3);
    applyStimulus(6'h04, 1'b0, 1'b1, V_DEC, 32'd3);
    applyStimulus(6'h04, 1'b0, 1'b1, V_BRN, 32'd3);
    // BEQ taken
    applyStimulus(6'h04, 1'b1, 1'b1, V_FGO, 32'd4);
    applyStimulus(6'h04, 1'b1, 1'b1, V_DEC, 32'd4);
    applyStimulus(6'h04, 1'b1, 1'b1, V_BRZ, 32'd4);
    // Jump
    applyStimulus(6'h05, 1'b0, 1'b1, V_FGO, 32'd5);
    applyStimulus(6'h05, 1'b0, 1'b1, V_DEC, 32'd5);
    applyStimulus(6'h05, 1'b0, 1'b1, V_JMP, 32'd5);
    // Illegal opcode 2A
    applyStimulus(6'h2A, 1'b0, 1'b1, V_FGO, 32'd6);
    applyStimulus(6'h2A, 1'b0, 1'b1, V_DEC_ILL, 32'd6);
    // SW
    applyStimulus(6'h03, 1'b0, 1'b1, V_FGO, 32'd7);
    applyStimulus(6'h03, 1'b0, 1'b1, V_DEC, 32'd7);
    applyStimulus(6'h03, 1'b0, 1'b1, V_ADDR, 32'd7);
    applyStimulus(6'h03, 1'b0, 1'b1, V_MW, 32'd7);
    // HALT is absorbing whatever the inputs do
    applyStimulus(6'h3F, 1'b0, 1'b1, V_FGO, 32'd8);
    applyStimulus(6'h3F, 1'b0, 1'b1, V_DEC, 32'd8);
    for (int i = 0; i < 22; i++)
      applyStimulus((i % 2 == 0) ? 6'h00 : 6'h3F, i[0], i[1], V_HLT, 32'd8);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    releaseReset();
    applyStimulus(6'h05, 1'b0, 1'b1, V_FGO, 32'd0);
    applyStimulus(6'h05, 1'b0, 1'b1, V_DEC, 32'd0);
    applyStimulus(6'h05, 1'b0, 1'b1, V_JMP, 32'd0);
    applyStimulus(6'h03, 1'b0, 1'b1, V_FGO, 32'd1);
    applyStimulus(6'h03, 1'b0, 1'b1, V_DEC, 32'd1);
    applyStimulus(6'h03, 1'b0, 1'b1, V_ADDR, 32'd1);
    applyStimulus(6'h03, 1'b0, 1'b0, V_MW, 32'd1);
    applyStimulus(6'h03, 1'b0, 1'b0, V_MW, 32'd1);
    // Reset lands between clock edges while the store is waiting
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", -2, obs_vec, V_IDLE, retired, 32'd0);

    releaseReset();
    applyStimulus(6'h00, 1'b0, 1'b1, V_FGO, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_DEC, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_EXR, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_WBR, 32'd0);
    applyStimulus(6'h00, 1'b0, 1'b1, V_FGO, 32'd1);

    @(negedge clk);
    #1;
    num_checks++;
    if (sb_q.size() != 0) begin
      num_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
